// File: rtl/scalable_vec_driver.sv
// scalable_vec_driver: LFSR operand source and MISR result reader for a 5-bit combinational datapath
// Ports: clk, rst_n (async active-low); start/abort run control; res = DUT result;
//        op_a/op_b = registered LFSR operands; busy (RUN), done (DONE); sig = MISR signature;
//        vec_cnt = vectors captured in the current or last run.
module scalable_vec_driver #(
  parameter int          N_VECTORS = 16,
  parameter int          SETTLE    = 1,
  parameter logic [4:0]  SEED_A    = 5'h01,
  parameter logic [4:0]  SEED_B    = 5'h1F
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [4:0] res,
  output logic [4:0] op_a,
  output logic [4:0] op_b,
  output logic       busy,
  output logic       done,
  output logic [4:0] sig,
  output logic [7:0] vec_cnt
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  // an all-zero seed would lock the LFSR at zero
  localparam logic [4:0] SA   = (SEED_A == 5'd0) ? 5'h01 : SEED_A;
  localparam logic [4:0] SB   = (SEED_B == 5'd0) ? 5'h01 : SEED_B;
  localparam logic [2:0] SW   = 3'(SETTLE);
  localparam logic [7:0] LAST = 8'(N_VECTORS - 1);

  logic [1:0] state_q, state_d;
  logic [4:0] op_a_q, op_a_d, op_b_q, op_b_d, sig_q, sig_d;
  logic [7:0] vec_cnt_q, vec_cnt_d;
  logic [2:0] wait_q, wait_d;

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    sig_d     = sig_q;
    vec_cnt_d = vec_cnt_q;
    wait_d    = wait_q;
    if ((state_q == IDLE || state_q == DONE) && start) begin
      state_d   = RUN;
      op_a_d    = SA;
      op_b_d    = SB;
      sig_d     = 5'd0;
      vec_cnt_d = 8'd0;
      wait_d    = SW;
    end else if (state_q == RUN) begin
      if (abort) state_d = IDLE;
      else if (wait_q != 3'd0) wait_d = wait_q - 3'd1;
      else begin
        sig_d     = {sig_q[3:0], sig_q[4] ^ sig_q[2]} ^ res;
        op_a_d    = {op_a_q[3:0], op_a_q[4] ^ op_a_q[2]};
        op_b_d    = {op_b_q[3:0], op_b_q[4] ^ op_b_q[2]};
        vec_cnt_d = vec_cnt_q + 8'd1;
        wait_d    = SW;
        state_d   = (vec_cnt_q == LAST) ? DONE : RUN;
      end
    end else if (state_q == 2'd3) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_a_q    <= SA;
      op_b_q    <= SB;
      sig_q     <= 5'd0;
      vec_cnt_q <= 8'd0;
      wait_q    <= 3'd0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      sig_q     <= sig_d;
      vec_cnt_q <= vec_cnt_d;
      wait_q    <= wait_d;
    end
  end

  assign op_a    = op_a_q;
  assign op_b    = op_b_q;
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign sig     = sig_q;
  assign vec_cnt = vec_cnt_q;
endmodule

// File: doc/scalable_vec_driver.md
# scalable_vec_driver

Sequential stimulus source and response reader for the 5-bit scalable datapath modules: it drives the operand pair `op_a`/`op_b` into a combinational device under test (DUT) and reads back the 5-bit result. Each run applies a programmable number of pseudo-random operand pairs and compresses every sampled result into a 5-bit MISR signature. It sits on the opposite side of the `in_0`/`in_1` → `out_0` interface, acting as initiator and reader for the datapath's responder role.

## Interface
- `N_VECTORS`, default 16: number of operand pairs per run; legal range 1..255.
- `SETTLE`, default 1: extra wait cycles between applying a vector and sampling `res`; legal range 0..7.
- `SEED_A`, default 5'h01: LFSR seed for `op_a`; a value of 0 is replaced by 5'h01 at load.
- `SEED_B`, default 5'h1F: LFSR seed for `op_b`; a value of 0 is replaced by 5'h01 at load.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: run request; sampled only in IDLE or DONE.
- `abort`, in, 1: cancels a run in progress; ignored outside RUN.
- `res`, in, 5: DUT result, sampled on capture edges.
- `op_a`, out, 5: operand A, driven from a register.
- `op_b`, out, 5: operand B, driven from a register.
- `busy`, out, 1: high while in RUN.
- `done`, out, 1: high while in DONE.
- `sig`, out, 5: MISR signature.
- `vec_cnt`, out, 8: number of vectors captured in the current or last run.

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset values: state IDLE; `op_a` = SEED_A; `op_b` = SEED_B (zero seeds replaced by 5'h01); `busy` = 0; `done` = 0; `sig` = 0; `vec_cnt` = 0; wait counter = 0.
- `busy` and `done` are decoded directly from the state register, with no extra delay.
- IDLE or DONE with `start` = 1:
  - load both LFSRs with their seeds;
  - clear `sig` and `vec_cnt`;
  - set the wait counter to SETTLE;
  - go to RUN.
- RUN with wait counter ≠ 0: decrement the wait counter; everything else holds.
- RUN with wait counter = 0 (capture edge):
  - `sig` ← {sig[3:0], sig[4]^sig[2]} ^ res;
  - both LFSRs advance;
  - `vec_cnt` increments;
  - the wait counter reloads to SETTLE.
  - If this is capture number N_VECTORS (i.e. `vec_cnt` was N_VECTORS-1 before the edge), go to DONE. LFSRs still advance on this edge.
- LFSR rule, same for A and B (x^5+x^3+1, period 31, never reaches 0): q ← {q[3:0], q[4]^q[2]}.
- DONE: `sig`, `vec_cnt`, `op_a` and `op_b` hold until the next `start`.
- `abort` in RUN: go to IDLE. `sig`, `vec_cnt` and the operands hold their current values; `done` is not asserted. `abort` has priority over a capture on the same edge, so no capture occurs.
- `start` in RUN: ignored.
- `start` and `abort` together in IDLE or DONE: `start` wins.
- `rst_n` low mid-run: immediate return to the reset values, regardless of the clock.

## Timing
- Let E0 be the edge where `start` is accepted. Vector k (k = 0..N-1) is driven from edge E0 + k·(SETTLE+1).
- Vector k is captured at edge E0 + (k+1)·(SETTLE+1).
- Each vector is held for exactly SETTLE+1 cycles, so the DUT has at least SETTLE+1 cycles of combinational settling time.
- `busy` rises at E0. At edge E0 + N·(SETTLE+1), `busy` falls and `done` rises.
- Total run length is N·(SETTLE+1) cycles.
- Back-to-back runs: `start` held high in DONE restarts on the next edge, which gives 1 DONE cycle between runs.

## Test plan
- Seed walk: SEED_A=5'h01, SEED_B=5'h1F, SETTLE=1, N=4, `res` = 0.
  - `op_a` must be 01, 02, 04, 09 and `op_b` must be 1F, 1E, 1C, 18, each value held for 2 cycles.
  - `done` rises 8 cycles after E0.
  - `sig` = 0 and `vec_cnt` = 4 at the end.
- MISR: `res` tied to 5'h01, SETTLE=0.
  - N=1 → `sig` = 5'h01.
  - N=2 → `sig` = 5'h03.
  - N=3 → `sig` = 5'h07.
- Abort: N=8, SETTLE=0; assert `abort` on the cycle after the 3rd capture.
  - Required: state IDLE, `done` = 0, `vec_cnt` = 3, `busy` = 0 one edge later.
  - A following `start` restarts from the seeds, with `sig` and `vec_cnt` cleared.
- Zero seed: SEED_A=0 → `op_a` = 5'h01 after reset and after `start`; `op_a` never equals 0 over 40 vectors.
- Reset mid-run: pulse `rst_n` low between clock edges during RUN.
  - All outputs return to their reset values asynchronously.
  - `start` pulses during RUN are ignored, and `vec_cnt` stays monotonic.
- Max settle: SETTLE=7, N=255 → `done` rises exactly 2040 cycles after E0 and `vec_cnt` = 255.
